// File: rtl/shift_rotate_pipelined_pkg.sv
// Shared definitions for the pipelined shifter/rotator.
// Mode encodings and the pipeline-depth helper.
package shift_rotate_pipelined_pkg;

    localparam logic [1:0] MODE_LSL = 2'd0;
    localparam logic [1:0] MODE_LSR = 2'd1;
    localparam logic [1:0] MODE_ASR = 2'd2;
    localparam logic [1:0] MODE_ROL = 2'd3;

    // Number of digit stages: ceil(clog2(width) / radix_log2), at least 1.
    function automatic int calc_stages(
        input int width,
        input int radix_log2
    );
        int shw;
        int n;
        shw = $clog2(width);
        n = (shw + radix_log2 - 1) / radix_log2;
        return (n < 1) ? 1 : n;
    endfunction

endpackage

// File: rtl/shift_rotate_stage.sv
// One combinational digit of the shifter: moves data by digit*STEP.
// Ports: data/digit/mode/sign in, moved out.
module shift_rotate_stage
    import shift_rotate_pipelined_pkg::*;
#(
    parameter int WIDTH      = 13,
    parameter int RADIX_LOG2 = 2,
    parameter int STEP       = 1
) (
    input  logic [WIDTH-1:0]      data,
    input  logic [RADIX_LOG2-1:0] digit,
    input  logic [1:0]            mode,
    input  logic                  sign,
    output logic [WIDTH-1:0]      moved
);

    localparam int WAYS = 1 << RADIX_LOG2;
    localparam logic [WIDTH-1:0] ONES = '1;

    logic [WIDTH-1:0]   lsl [WAYS];
    logic [WIDTH-1:0]   lsr [WAYS];
    logic [WIDTH-1:0]   asr [WAYS];
    logic [WIDTH-1:0]   rol [WAYS];
    logic [2*WIDTH-1:0] dd;
    logic [WIDTH-1:0]   fill;

    assign dd   = {data, data};
    assign fill = {WIDTH{sign}};

    // Every way has a constant move amount, so each candidate is
    // pure wiring; only the final select is a real mux.
    for (genvar k = 0; k < WAYS; k++) begin : g_way
        localparam int AMT = k * STEP;
        localparam int ROT = AMT % WIDTH;

        if (AMT >= WIDTH) begin : g_over
            assign lsl[k] = '0;
            assign lsr[k] = '0;
            assign asr[k] = fill;
        end else begin : g_in
            assign lsl[k] = data << AMT;
            assign lsr[k] = data >> AMT;
            // sign is the original operand MSB, not data[WIDTH-1]
            assign asr[k] = (data >> AMT) | (fill & ~(ONES >> AMT));
        end

        // Rotation wraps modulo WIDTH, so oversize amounts need no care.
        assign rol[k] = dd[2*WIDTH-1-ROT -: WIDTH];
    end

    always_comb begin
        moved = data;
        unique case (mode)
            MODE_LSL: moved = lsl[digit];
            MODE_LSR: moved = lsr[digit];
            MODE_ASR: moved = asr[digit];
            MODE_ROL: moved = rol[digit];
        endcase
    end

endmodule

// File: rtl/shift_rotate_pipelined.sv
// Pipelined barrel shifter/rotator (LSL/LSR/ASR/ROL), one digit/stage.
// Ports: clk, resetN, flush, in/shift/mode/tagIn/validIn/readyIn
// upstream; out/tagOut/validOut/readyOut downstream.
module shift_rotate_pipelined
    import shift_rotate_pipelined_pkg::*;
#(
    parameter int WIDTH      = 13,
    parameter int RADIX_LOG2 = 2,
    parameter int TAG_WIDTH  = 4,
    parameter int SHW        = $clog2(WIDTH),
    parameter int STAGES     = calc_stages(WIDTH, RADIX_LOG2)
) (
    input  logic                 clk,
    input  logic                 resetN,
    input  logic                 flush,
    input  logic [WIDTH-1:0]     in,
    input  logic [SHW-1:0]       shift,
    input  logic [1:0]           mode,
    input  logic [TAG_WIDTH-1:0] tagIn,
    input  logic                 validIn,
    output logic                 readyIn,
    output logic [WIDTH-1:0]     out,
    output logic [TAG_WIDTH-1:0] tagOut,
    output logic                 validOut,
    input  logic                 readyOut
);

    // Shift amount padded on top to a whole number of digits.
    localparam int SHP = STAGES * RADIX_LOG2;

    logic [STAGES-1:0]    v_q;
    logic [WIDTH-1:0]     d_q  [STAGES];
    logic [TAG_WIDTH-1:0] t_q  [STAGES];
    logic [1:0]           m_q  [STAGES];
    logic                 s_q  [STAGES];
    logic [SHP-1:0]       sh_q [STAGES];

    logic [STAGES-1:0]    src_v;
    logic [WIDTH-1:0]     src_d  [STAGES];
    logic [TAG_WIDTH-1:0] src_t  [STAGES];
    logic [1:0]           src_m  [STAGES];
    logic                 src_s  [STAGES];
    logic [SHP-1:0]       src_sh [STAGES];

    logic [WIDTH-1:0]     nxt_d  [STAGES];
    logic [SHP-1:0]       nxt_sh [STAGES];

    logic [STAGES-1:0]    adv;
    logic                 go;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        if (s == 0) begin : g_src_in
            assign src_v[s]  = validIn;
            assign src_d[s]  = in;
            assign src_t[s]  = tagIn;
            assign src_m[s]  = mode;
            assign src_s[s]  = in[WIDTH-1];
            assign src_sh[s] = SHP'(shift);
        end else begin : g_src_reg
            assign src_v[s]  = v_q[s-1];
            assign src_d[s]  = d_q[s-1];
            assign src_t[s]  = t_q[s-1];
            assign src_m[s]  = m_q[s-1];
            assign src_s[s]  = s_q[s-1];
            assign src_sh[s] = sh_q[s-1];
        end

        // Most significant digit first; consumed digits shift out
        // so the next stage always reads the top digit.
        shift_rotate_stage #(
            .WIDTH      (WIDTH),
            .RADIX_LOG2 (RADIX_LOG2),
            .STEP       (1 << (RADIX_LOG2 * (STAGES - 1 - s)))
        ) u_stage (
            .data  (src_d[s]),
            .digit (src_sh[s][SHP-1 -: RADIX_LOG2]),
            .mode  (src_m[s]),
            .sign  (src_s[s]),
            .moved (nxt_d[s])
        );

        assign nxt_sh[s] = src_sh[s] << RADIX_LOG2;
    end

    // A stage advances when it is empty or its item moves on;
    // walking from the output back lets bubbles collapse.
    always_comb begin
        adv = '0;
        go  = readyOut;
        for (int s = STAGES - 1; s >= 0; s--) begin
            go     = !v_q[s] || go;
            adv[s] = go;
        end
    end

    assign readyIn  = adv[0] && !flush;
    assign out      = d_q[STAGES-1];
    assign tagOut   = t_q[STAGES-1];
    assign validOut = v_q[STAGES-1];

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            v_q <= '0;
            for (int s = 0; s < STAGES; s++) begin
                d_q[s]  <= '0;
                t_q[s]  <= '0;
                m_q[s]  <= '0;
                s_q[s]  <= 1'b0;
                sh_q[s] <= '0;
            end
        end else if (flush) begin
            v_q <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                if (adv[s]) begin
                    v_q[s]  <= src_v[s];
                    d_q[s]  <= nxt_d[s];
                    t_q[s]  <= src_t[s];
                    m_q[s]  <= src_m[s];
                    s_q[s]  <= src_s[s];
                    sh_q[s] <= nxt_sh[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_shift_rotate_pipelined.sv
// Self-checking bench for shift_rotate_pipelined.
// Directed WIDTH=13 tests plus randomised multi-config cross-check.
module tb_shift_rotate_pipelined;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_done   = 0;

    logic rst0;
    logic rstr;

    task automatic check(
        input string       tag,
        input logic [63:0] got,
        input logic [63:0] exp
    );
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: direct arithmetic on the whole shift amount.
    function automatic logic [63:0] ref_op(
        input int          w,
        input logic [63:0] x,
        input int          sh,
        input int          md
    );
        logic [63:0] mask;
        longint      sx;
        int          r;
        mask = (64'd1 << w) - 64'd1;
        case (md)
            0: return (sh >= w) ? 64'd0 : (x << sh) & mask;
            1: return (sh >= w) ? 64'd0 : (x >> sh);
            2: begin
                sx = x[w-1] ? longint'(x) - (longint'(1) << w)
                            : longint'(x);
                return $unsigned(sx >>> sh) & mask;
            end
            default: begin
                r = sh % w;
                return ((x << r) | (x >> (w - r))) & mask;
            end
        endcase
    endfunction

    // ---------------- directed DUT (13 / 2) ----------------
    logic [12:0] d_in, d_out;
    logic [3:0]  d_sh;
    logic [1:0]  d_md;
    logic [3:0]  d_tg, d_to;
    logic        d_vi, d_ri, d_vo, d_ro, d_fl;

    shift_rotate_pipelined #(
        .WIDTH(13), .RADIX_LOG2(2), .TAG_WIDTH(4)
    ) u_dut (
        .clk      (clk),
        .resetN   (rst0),
        .flush    (d_fl),
        .in       (d_in),
        .shift    (d_sh),
        .mode     (d_md),
        .tagIn    (d_tg),
        .validIn  (d_vi),
        .readyIn  (d_ri),
        .out      (d_out),
        .tagOut   (d_to),
        .validOut (d_vo),
        .readyOut (d_ro)
    );

    task automatic send_check(
        input string       name,
        input logic [12:0] x,
        input logic [3:0]  sh,
        input logic [1:0]  md,
        input logic [3:0]  tg,
        input logic [12:0] exp
    );
        @(negedge clk);
        d_in = x; d_sh = sh; d_md = md; d_tg = tg;
        d_vi = 1'b1; d_ro = 1'b1;
        #1 check({name, "_rdy"}, 64'(d_ri), 64'd1);
        @(negedge clk);
        d_vi = 1'b0;
        #1 check({name, "_lat1"}, 64'(d_vo), 64'd0);
        @(negedge clk);
        #1;
        check({name, "_vo"}, 64'(d_vo), 64'd1);
        check({name, "_out"}, 64'(d_out), 64'(exp));
        check({name, "_tag"}, 64'(d_to), 64'(tg));
    endtask

    task automatic push_item(input logic [12:0] x, input logic [3:0] tg);
        @(negedge clk);
        d_in = x; d_sh = 4'd0; d_md = 2'd0; d_tg = tg; d_vi = 1'b1;
        #1 check("push_rdy", 64'(d_ri), 64'd1);
    endtask

    logic [12:0] bp_in  [6];
    logic [3:0]  bp_sh  [6];
    logic [1:0]  bp_md  [6];
    logic [63:0] bp_exp [6];

    initial begin
        int          sent;
        int          got;
        logic        prev_hold;
        logic [63:0] prev;
        logic [12:0] x;

        rst0 = 1'b0; rstr = 1'b0;
        d_in = '0; d_sh = '0; d_md = '0; d_tg = '0;
        d_vi = 1'b0; d_ro = 1'b0; d_fl = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_vo", 64'(d_vo), 64'd0);
        check("rst_out", 64'(d_out), 64'd0);
        check("rst_tag", 64'(d_to), 64'd0);
        rst0 = 1'b1; rstr = 1'b1;
        #1 check("rst_rdy", 64'(d_ri), 64'd1);

        send_check("lsl12", 13'h0001, 4'd12, 2'd0, 4'h5, 13'h1000);
        send_check("asr4", 13'h1000, 4'd4, 2'd2, 4'h6, 13'h1F00);
        send_check("lsr4", 13'h1000, 4'd4, 2'd1, 4'h7, 13'h0100);
        send_check("rol15", 13'h1801, 4'd15, 2'd3, 4'h8, 13'h0007);
        send_check("lsr13", 13'h1FFF, 4'd13, 2'd1, 4'h9, 13'h0000);
        send_check("lsr14", 13'h1FFF, 4'd14, 2'd1, 4'hA, 13'h0000);
        send_check("lsr15", 13'h1FFF, 4'd15, 2'd1, 4'hB, 13'h0000);
        send_check("asr15", 13'h1000, 4'd15, 2'd2, 4'hC, 13'h1FFF);
        for (int m = 0; m < 4; m++) begin
            x = 13'($urandom);
            send_check("sh0", x, 4'd0, 2'(m), 4'(m), x);
        end

        // backpressure: 6 items, readyOut low for 5 cycles mid-stream
        for (int i = 0; i < 6; i++) begin
            bp_in[i] = 13'($urandom);
            bp_sh[i] = 4'($urandom);
            bp_md[i] = 2'($urandom);
            bp_exp[i] = (64'(i + 1) << 13)
                      | ref_op(13, 64'(bp_in[i]), int'(bp_sh[i]),
                               int'(bp_md[i]));
        end
        sent = 0; got = 0; prev_hold = 1'b0; prev = '0;
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            d_ro = !(c >= 4 && c < 9);
            d_vi = (sent < 6);
            if (sent < 6) begin
                d_in = bp_in[sent]; d_sh = bp_sh[sent];
                d_md = bp_md[sent]; d_tg = 4'(sent + 1);
            end
            #1;
            if (prev_hold) begin
                check("bp_hold_vo", 64'(d_vo), 64'd1);
                check("bp_hold_out", {47'd0, d_to, d_out}, prev);
            end
            check("bp_rdy", 64'(d_ri),
                  64'(!((sent - got) == 2 && !d_ro)));
            prev_hold = d_vo && !d_ro;
            prev = {47'd0, d_to, d_out};
            if (d_vo && d_ro) begin
                check("bp_out", {47'd0, d_to, d_out}, bp_exp[got]);
                got++;
            end
            if (d_vi && d_ri) sent++;
        end
        check("bp_count", 64'(got), 64'd6);

        // flush with two items in flight
        @(negedge clk);
        d_vi = 1'b0; d_ro = 1'b0;
        push_item(13'h0AAA, 4'h7);
        push_item(13'h0555, 4'h8);
        @(negedge clk);
        d_fl = 1'b1; d_vi = 1'b1; d_tg = 4'h9;
        #1 check("fl_rdy", 64'(d_ri), 64'd0);
        @(negedge clk);
        d_fl = 1'b0; d_vi = 1'b0; d_ro = 1'b1;
        #1;
        check("fl_vo", 64'(d_vo), 64'd0);
        check("fl_rdy_after", 64'(d_ri), 64'd1);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check("fl_empty", 64'(d_vo), 64'd0);
        end

        // asynchronous reset between clock edges
        d_ro = 1'b0;
        push_item(13'h1ABC, 4'hD);
        push_item(13'h0123, 4'hE);
        @(negedge clk);
        d_vi = 1'b0;
        #1 check("ar_pre_vo", 64'(d_vo), 64'd1);
        #2 rst0 = 1'b0;
        #1;
        check("ar_vo", 64'(d_vo), 64'd0);
        check("ar_out", 64'(d_out), 64'd0);
        check("ar_tag", 64'(d_to), 64'd0);
        rst0 = 1'b1;
        @(negedge clk);
        #1;
        check("ar_rdy", 64'(d_ri), 64'd1);
        check("ar_vo_after", 64'(d_vo), 64'd0);

        for (int c = 0; c < 5000 && n_done < 4; c++) @(negedge clk);
        check("rand_done", 64'(n_done), 64'd4);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    // ---------------- randomised configs ----------------
    for (genvar g = 0; g < 4; g++) begin : g_rand
        localparam int W  = (g == 3) ? 13 : 32;
        localparam int R  = (g == 3) ? 3 : g + 1;
        localparam int SW = $clog2(W);

        logic [W-1:0]  r_in, r_out;
        logic [SW-1:0] r_sh;
        logic [1:0]    r_md;
        logic [3:0]    r_tg, r_to;
        logic          r_vi, r_ri, r_vo, r_ro;
        logic [63:0]   q [$];

        shift_rotate_pipelined #(
            .WIDTH(W), .RADIX_LOG2(R), .TAG_WIDTH(4)
        ) u_dut (
            .clk      (clk),
            .resetN   (rstr),
            .flush    (1'b0),
            .in       (r_in),
            .shift    (r_sh),
            .mode     (r_md),
            .tagIn    (r_tg),
            .validIn  (r_vi),
            .readyIn  (r_ri),
            .out      (r_out),
            .tagOut   (r_to),
            .validOut (r_vo),
            .readyOut (r_ro)
        );

        initial begin
            r_in = '0; r_sh = '0; r_md = '0; r_tg = '0;
            r_vi = 1'b0; r_ro = 1'b0;
            wait (rstr == 1'b1);
            for (int c = 0; c < 640; c++) begin
                @(negedge clk);
                r_vi = (c < 600) && ($urandom_range(0, 3) != 0);
                r_ro = (c >= 600) || ($urandom_range(0, 2) != 0);
                r_in = W'($urandom);
                r_sh = SW'($urandom);
                r_md = 2'($urandom);
                r_tg = 4'($urandom);
                #1;
                if (r_vo && r_ro) begin
                    if (q.size() == 0)
                        check("rand_extra", 64'd1, 64'd0);
                    else
                        check("rand_out",
                              (64'(r_to) << W) | 64'(r_out),
                              q.pop_front());
                end
                if (r_vi && r_ri)
                    q.push_back((64'(r_tg) << W)
                              | ref_op(W, 64'(r_in), int'(r_sh),
                                       int'(r_md)));
            end
            check("rand_lost", 64'(q.size()), 64'd0);
            n_done++;
        end
    end

endmodule
